// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Purpose:
//   Instruction-fetch front end for the CPU. It owns the fetch PC and issues
//   one word request at a time to a variable-latency instruction memory over
//   a req/ack handshake. Returned words are stored with their PCs in a small
//   FIFO, and the FIFO head is handed to decode over a valid/ready handshake.
//   A branch, jump or jr redirect flushes the queue and restarts fetch at
//   the new target. If a request is still in flight when the redirect
//   arrives, that request is allowed to finish and its data is discarded.
//
// Parameters:
//   DEPTH     queue entries (power of 2, at least 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-low reset
//   mem_req_o      fetch request to instruction memory
//   mem_addr_o     fetch address, held stable while mem_req_o=1
//   mem_ack_i      memory returns data this cycle (ignored while req=0)
//   mem_instr_i    returned instruction word, valid with mem_ack_i
//   redirect_i     datapath takes a branch/jump/jr
//   redirect_pc_i  new fetch target (low 2 bits ignored)
//   instr_ready_i  datapath consumes the head entry this cycle
//   instr_valid_o  head entry valid
//   instr_o        head instruction (0 when empty)
//   pc_o           head instruction address (0 when empty)
//   pc_plus4_o     pc_o + 4
//   count_o        current queue occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_instr_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    input  logic                     instr_ready_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              pc_plus4_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // IDLE: no request. REQ: request outstanding, data will be kept.
    // KILL: request outstanding whose data belongs to a flushed path.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetchState_t;

    fetchState_t       r_state;
    fetchState_t       w_nextState;
    logic [31:0]       r_fetchPc;
    logic [31:0]       w_nextFetchPc;
    logic [31:0]       r_killPc;
    logic [31:0]       w_nextKillPc;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_instrMem [DEPTH];
    logic [31:0]       r_pcMem    [DEPTH];

    logic              w_reqActive;
    logic              w_ack;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic [31:0]       w_redirPc;
    logic [CNT_W-1:0]  w_countAfterPop;

    // A request is outstanding in both REQ and KILL. Acks seen with no
    // request outstanding are simply masked off.
    assign w_reqActive     = (r_state != IDLE);
    assign w_ack           = mem_ack_i & w_reqActive;
    assign w_valid         = (r_count != '0);
    assign w_pop           = w_valid & instr_ready_i & ~redirect_i;
    assign w_redirPc       = redirect_pc_i & ~32'h0000_0003;
    assign w_countAfterPop = r_count - CNT_W'(w_pop);

    // Next-state logic. A new request is issued only when a queue slot is
    // guaranteed to be free by the time its data returns, so the queue can
    // never overflow. While in KILL the memory still sees the original
    // address so the in-flight transfer completes cleanly.
    always_comb begin
        w_nextState   = r_state;
        w_nextFetchPc = r_fetchPc;
        w_nextKillPc  = r_killPc;
        w_push        = 1'b0;
        mem_addr_o    = r_fetchPc;

        case (r_state)
            IDLE: begin
                if (redirect_i) begin
                    w_nextFetchPc = w_redirPc;
                    w_nextState   = REQ;
                end else if (w_countAfterPop < DEPTH_C) begin
                    w_nextState = REQ;
                end
            end

            REQ: begin
                if (redirect_i) begin
                    w_nextFetchPc = w_redirPc;
                    if (w_ack) begin
                        w_nextState = REQ;
                    end else begin
                        w_nextKillPc = r_fetchPc;
                        w_nextState  = KILL;
                    end
                end else if (w_ack) begin
                    w_push        = 1'b1;
                    w_nextFetchPc = r_fetchPc + 32'd4;
                    // Keep requesting only if one more slot stays free once
                    // this word has been pushed.
                    if (w_countAfterPop < (DEPTH_C - CNT_W'(1))) begin
                        w_nextState = REQ;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end

            KILL: begin
                mem_addr_o = r_killPc;
                if (redirect_i) begin
                    w_nextFetchPc = w_redirPc;
                end
                if (w_ack) begin
                    w_nextState = REQ;
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, PC and queue bookkeeping. A redirect flushes the queue in the
    // same edge, and any pop requested in that cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_fetchPc <= RESET_PC;
            r_killPc  <= RESET_PC;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_fetchPc <= w_nextFetchPc;
            r_killPc  <= w_nextKillPc;
            if (redirect_i) begin
                r_rdPtr <= '0;
                r_wrPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Queue storage. It needs no reset because the head is only exposed
    // while the occupancy count says it is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= mem_instr_i;
            r_pcMem[r_wrPtr]    <= r_fetchPc;
        end
    end

    assign mem_req_o     = w_reqActive;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_instrMem[r_rdPtr] : 32'd0;
    assign pc_o          = w_valid ? r_pcMem[r_rdPtr] : 32'd0;
    assign pc_plus4_o    = pc_o + 32'd4;
    assign count_o       = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Drives instr_fetch_queue with a small instruction-memory model. The model
// has a programmable latency and returns the bitwise inverse of the address
// as the instruction word. A vector table covers streaming and queue-full
// behaviour. Hand-written sequences cover slow memory, killed fetches,
// coincident redirect/ack/pop, PC wrap and reset in the middle of a request.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk_i;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [2:0]  count_o;

    int    total;
    int    bad;
    int    memLat;
    int    waitCnt;
    string curTag;

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_instr_i   (mem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_ready_i (instr_ready_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .count_o       (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // The memory acks once a request has been held for memLat cycles.
    // With memLat=1 it acks in the same cycle the request appears.
    assign mem_ack_i   = mem_req_o && (waitCnt >= memLat - 1);
    assign mem_instr_i = ~mem_addr_o;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            waitCnt <= 0;
        end else if (mem_ack_i || !mem_req_o) begin
            waitCnt <= 0;
        end else begin
            waitCnt <= waitCnt + 1;
        end
    end

    typedef struct {
        logic        rstBefore;
        logic        ready;
        logic        redir;
        logic [31:0] redirPc;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        int          expCount;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s %s: got %h want %h", curTag, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] redirPc);
        rst_i         = 1'b1;
        instr_ready_i = ready;
        redirect_i    = redir;
        redirect_pc_i = redirPc;
    endtask

    task automatic checkOutput(input logic expReq, input logic [31:0] expAddr,
                               input logic expValid, input logic [31:0] expPc,
                               input int expCount);
        logic [31:0] expInstr;
        expInstr = expValid ? ~expPc : 32'd0;
        check("req",   {31'd0, mem_req_o},     {31'd0, expReq});
        if (expReq) begin
            check("addr", mem_addr_o, expAddr);
        end
        check("valid", {31'd0, instr_valid_o}, {31'd0, expValid});
        check("instr", instr_o, expInstr);
        check("pc",    pc_o, expPc);
        check("pc4",   pc_plus4_o, expPc + 32'd4);
        check("count", {29'd0, count_o}, expCount[31:0]);
    endtask

    // One cycle: drive inputs just after the edge, check at the falling edge.
    task automatic stepCycle(input string tag, input logic ready, input logic redir,
                             input logic [31:0] redirPc, input logic expReq,
                             input logic [31:0] expAddr, input logic expValid,
                             input logic [31:0] expPc, input int expCount);
        curTag = tag;
        applyStimulus(ready, redir, redirPc);
        @(negedge clk_i);
        checkOutput(expReq, expAddr, expValid, expPc, expCount);
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset(input int edges);
        rst_i         = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        repeat (edges) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // With 3-cycle memory and ready=0, this fetches three words and leaves
    // the fourth request (0xC) starting in the following cycle.
    task automatic fillSlow(input string tag);
        stepCycle({tag, " c0"}, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        stepCycle({tag, " c1"}, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0);
        stepCycle({tag, " c2"}, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0);
        stepCycle({tag, " c3"}, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0);
        stepCycle({tag, " c4"}, 0, 0, 0, 1, 32'h4, 1, 32'h0, 1);
        stepCycle({tag, " c5"}, 0, 0, 0, 1, 32'h4, 1, 32'h0, 1);
        stepCycle({tag, " c6"}, 0, 0, 0, 1, 32'h4, 1, 32'h0, 1);
        stepCycle({tag, " c7"}, 0, 0, 0, 1, 32'h8, 1, 32'h0, 2);
        stepCycle({tag, " c8"}, 0, 0, 0, 1, 32'h8, 1, 32'h0, 2);
        stepCycle({tag, " c9"}, 0, 0, 0, 1, 32'h8, 1, 32'h0, 2);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        memLat        = 1;
        rst_i         = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;

        // Streaming with ready=1, then filling the queue with ready=0.
        //          rst ready redir pc   req addr        vld pc          cnt
        vecs[0]  = '{1, 1, 0, 0, 0, 32'h00, 0, 32'h00, 0};
        vecs[1]  = '{0, 1, 0, 0, 1, 32'h00, 0, 32'h00, 0};
        vecs[2]  = '{0, 1, 0, 0, 1, 32'h04, 1, 32'h00, 1};
        vecs[3]  = '{0, 1, 0, 0, 1, 32'h08, 1, 32'h04, 1};
        vecs[4]  = '{0, 1, 0, 0, 1, 32'h0C, 1, 32'h08, 1};
        vecs[5]  = '{0, 1, 0, 0, 1, 32'h10, 1, 32'h0C, 1};
        vecs[6]  = '{1, 0, 0, 0, 0, 32'h00, 0, 32'h00, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 32'h04, 1, 32'h00, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 32'h08, 1, 32'h00, 2};
        vecs[10] = '{0, 0, 0, 0, 1, 32'h0C, 1, 32'h00, 3};
        vecs[11] = '{0, 0, 0, 0, 0, 32'h10, 1, 32'h00, 4};
        vecs[12] = '{0, 0, 0, 0, 0, 32'h10, 1, 32'h00, 4};
        vecs[13] = '{0, 1, 0, 0, 0, 32'h10, 1, 32'h00, 4};
        vecs[14] = '{0, 1, 0, 0, 1, 32'h10, 1, 32'h04, 3};
        vecs[15] = '{0, 1, 0, 0, 1, 32'h14, 1, 32'h08, 3};
        vecs[16] = '{0, 1, 0, 0, 1, 32'h18, 1, 32'h0C, 3};
        vecs[17] = '{0, 1, 0, 0, 1, 32'h1C, 1, 32'h10, 3};

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rstBefore) begin
                memLat = 1;
                doReset(2);
            end
            stepCycle($sformatf("vec%0d", i), vecs[i].ready, vecs[i].redir, vecs[i].redirPc,
                      vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid,
                      vecs[i].expPc, vecs[i].expCount);
        end

        // Slow memory: address held for 3 cycles, pops come out in order.
        memLat = 3;
        doReset(2);
        fillSlow("slow");
        stepCycle("slow c10", 1, 0, 0, 1, 32'h0C, 1, 32'h00, 3);
        stepCycle("slow c11", 1, 0, 0, 1, 32'h0C, 1, 32'h04, 2);
        stepCycle("slow c12", 1, 0, 0, 1, 32'h0C, 1, 32'h08, 1);
        stepCycle("slow c13", 0, 0, 0, 1, 32'h10, 1, 32'h0C, 1);

        // Redirect to 0x40 while the fetch of 0x8 is still in flight.
        memLat = 3;
        doReset(2);
        stepCycle("kill c0", 0, 0, 0, 0, 32'h00, 0, 32'h00, 0);
        stepCycle("kill c1", 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
        stepCycle("kill c2", 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
        stepCycle("kill c3", 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
        stepCycle("kill c4", 0, 0, 0, 1, 32'h04, 1, 32'h00, 1);
        stepCycle("kill c5", 0, 0, 0, 1, 32'h04, 1, 32'h00, 1);
        stepCycle("kill c6", 0, 0, 0, 1, 32'h04, 1, 32'h00, 1);
        stepCycle("kill c7", 0, 0, 0, 1, 32'h08, 1, 32'h00, 2);
        stepCycle("kill c8", 0, 1, 32'h40, 1, 32'h08, 1, 32'h00, 2);
        stepCycle("kill c9", 0, 0, 0, 1, 32'h08, 0, 32'h00, 0);
        stepCycle("kill c10", 0, 0, 0, 1, 32'h40, 0, 32'h00, 0);
        stepCycle("kill c11", 0, 0, 0, 1, 32'h40, 0, 32'h00, 0);
        stepCycle("kill c12", 0, 0, 0, 1, 32'h40, 0, 32'h00, 0);
        stepCycle("kill c13", 0, 0, 0, 1, 32'h44, 1, 32'h40, 1);

        // Redirect together with ack and pop; the target's low bits are dropped.
        memLat = 1;
        doReset(2);
        stepCycle("coin c0", 1, 0, 0, 0, 32'h000, 0, 32'h000, 0);
        stepCycle("coin c1", 1, 0, 0, 1, 32'h000, 0, 32'h000, 0);
        stepCycle("coin c2", 1, 1, 32'h103, 1, 32'h004, 1, 32'h000, 1);
        stepCycle("coin c3", 0, 0, 0, 1, 32'h100, 0, 32'h000, 0);
        stepCycle("coin c4", 0, 0, 0, 1, 32'h104, 1, 32'h100, 1);

        // Redirect from IDLE to the last word of the address space.
        memLat = 1;
        doReset(2);
        stepCycle("wrap c0", 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0);
        stepCycle("wrap c1", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        stepCycle("wrap c2", 0, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 1);

        // Reset with three entries queued and a request outstanding.
        memLat = 3;
        doReset(2);
        fillSlow("mrst");
        stepCycle("mrst c10", 0, 0, 0, 1, 32'h0C, 1, 32'h00, 3);
        doReset(1);
        stepCycle("mrst r0", 0, 0, 0, 0, 32'h00, 0, 32'h00, 0);
        stepCycle("mrst r1", 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
